gb_frame_ctrl: RTL and testbench

GB_FRAME_CTRL -- requirements
Module: gb_frame_ctrl

---
 rtl/gb_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_gb_frame_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_frame_ctrl.sv
// rtl/gb_frame_ctrl.sv - frame sequencer: DUT register setup, pixel streaming, IRQ acknowledge, idle watchdog
// Ports:
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   start, busy, done       frame request, not-idle flag, one-cycle success pulse
//   timeout_err             sticky error flag (watchdog expiry or bad write response)
//   src_*                   pixel source stream feeding the controller
//   arg_1_*                 pixel stream into the DUT, TLAST on the final pixel
//   arg_0_*                 DUT result stream, drained and counted, data ignored
//   interrupt               DUT completion interrupt
//   m_axi_config_*          AXI-lite write master to the DUT control registers
module gb_frame_ctrl #(
    parameter int IN_PIXELS  = 16,
    parameter int OUT_PIXELS = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    input  logic [7:0]  src_TDATA,
    input  logic        src_TVALID,
    output logic        src_TREADY,
    output logic [7:0]  arg_1_TDATA,
    output logic        arg_1_TVALID,
    input  logic        arg_1_TREADY,
    output logic        arg_1_TLAST,
    input  logic        arg_0_TVALID,
    output logic        arg_0_TREADY,
    input  logic        interrupt,
    output logic        m_axi_config_AWVALID,
    input  logic        m_axi_config_AWREADY,
    output logic [4:0]  m_axi_config_AWADDR,
    output logic        m_axi_config_WVALID,
    input  logic        m_axi_config_WREADY,
    output logic [31:0] m_axi_config_WDATA,
    output logic [3:0]  m_axi_config_WSTRB,
    input  logic        m_axi_config_BVALID,
    output logic        m_axi_config_BREADY,
    input  logic [1:0]  m_axi_config_BRESP
);
    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_CFG_B, S_RUN, S_WAIT_IRQ, S_CLR, S_CLR_B, S_DONE, S_ERR
    } state_t;

    localparam logic [18:0] IN_LIM  = 19'(IN_PIXELS);
    localparam logic [18:0] OUT_LIM = 19'(OUT_PIXELS);
    localparam logic [16:0] TO_LIM  = 17'(TIMEOUT);

    state_t      state, next_state;
    logic [18:0] in_cnt, out_cnt;
    logic [15:0] idle_cnt;
    logic [1:0]  k;
    logic        aw_done, w_done, err_flag;

    logic wr_phase, b_phase, in_open, counting;
    logic aw_hs, w_hs, b_hs, in_hs, out_hs, activity, both_done, timeout_hit;

    assign wr_phase  = (state == S_CFG) || (state == S_CLR);
    assign b_phase   = (state == S_CFG_B) || (state == S_CLR_B);
    assign in_open   = (state == S_RUN) && (in_cnt < IN_LIM);
    assign counting  = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
    assign aw_hs     = m_axi_config_AWVALID & m_axi_config_AWREADY;
    assign w_hs      = m_axi_config_WVALID & m_axi_config_WREADY;
    assign b_hs      = m_axi_config_BVALID & m_axi_config_BREADY;
    assign in_hs     = arg_1_TVALID & arg_1_TREADY;
    assign out_hs    = arg_0_TVALID & arg_0_TREADY;
    assign activity  = aw_hs | w_hs | b_hs | in_hs | out_hs | interrupt;
    // AW and W complete independently; the write is finished once both have been seen
    assign both_done = (aw_done | aw_hs) & (w_done | w_hs);
    // any beat in the threshold cycle wins over the watchdog
    assign timeout_hit = counting && !activity && (({1'b0, idle_cnt} + 17'd1) >= TO_LIM);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = S_CFG;
            S_CFG:      if (both_done) next_state = S_CFG_B;
            S_CFG_B: begin
                if (b_hs) begin
                    if (m_axi_config_BRESP != 2'b00) next_state = S_ERR;
                    else if (k == 2'd2)              next_state = S_RUN;
                    else                             next_state = S_CFG;
                end
            end
            S_RUN:      if (in_cnt == IN_LIM && out_cnt == OUT_LIM) next_state = S_WAIT_IRQ;
            S_WAIT_IRQ: if (interrupt) next_state = S_CLR;
            S_CLR:      if (both_done) next_state = S_CLR_B;
            S_CLR_B: begin
                if (b_hs) next_state = (m_axi_config_BRESP != 2'b00) ? S_ERR : S_DONE;
            end
            S_DONE:     next_state = S_IDLE;
            S_ERR:      if (start) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
        if (timeout_hit) next_state = S_ERR;
    end

    always_comb begin
        busy                 = (state != S_IDLE);
        done                 = (state == S_DONE);
        timeout_err          = err_flag;
        m_axi_config_AWVALID = wr_phase && !aw_done;
        m_axi_config_WVALID  = wr_phase && !w_done;
        m_axi_config_WSTRB   = 4'hF;
        m_axi_config_BREADY  = b_phase;
        m_axi_config_AWADDR  = 5'h00;
        m_axi_config_WDATA   = 32'd0;
        if (wr_phase) begin
            m_axi_config_WDATA = 32'd1;
            if (state == S_CLR) begin
                m_axi_config_AWADDR = 5'h0C;
            end else begin
                case (k)
                    2'd0:    m_axi_config_AWADDR = 5'h04;
                    2'd1:    m_axi_config_AWADDR = 5'h08;
                    default: m_axi_config_AWADDR = 5'h00;
                endcase
            end
        end
        // source passes straight through to the DUT until the frame's pixels are in
        arg_1_TVALID = in_open & src_TVALID;
        src_TREADY   = in_open & arg_1_TREADY;
        arg_1_TDATA  = in_open ? src_TDATA : 8'h00;
        arg_1_TLAST  = arg_1_TVALID && (in_cnt == IN_LIM - 19'd1);
        arg_0_TREADY = (state == S_RUN) || (state == S_WAIT_IRQ);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            idle_cnt <= '0;
            k        <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            err_flag <= 1'b0;
        end else if (state == S_IDLE && start) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            idle_cnt <= '0;
            k        <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            if (in_hs) in_cnt <= in_cnt + 19'd1;
            if (out_hs && out_cnt < OUT_LIM) out_cnt <= out_cnt + 19'd1;
            if (state == S_CFG_B && b_hs && m_axi_config_BRESP == 2'b00 && k != 2'd2) k <= k + 2'd1;
            if (activity)      idle_cnt <= '0;
            else if (counting) idle_cnt <= idle_cnt + 16'd1;
            // handshake memory only lives while the write phase continues
            if (wr_phase && next_state == state) begin
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | w_hs;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (next_state == S_ERR) err_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gb_frame_ctrl.sv
// tb/tb_gb_frame_ctrl.sv - self-checking bench for gb_frame_ctrl with stream/AXI-lite responders
module tb_gb_frame_ctrl;
    localparam int IN  = 4;
    localparam int OUT = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n, start, busy, done, timeout_err;
    logic [7:0]  src_TDATA;
    logic        src_TVALID, src_TREADY;
    logic [7:0]  arg_1_TDATA;
    logic        arg_1_TVALID, arg_1_TREADY, arg_1_TLAST;
    logic        arg_0_TVALID, arg_0_TREADY, interrupt;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [4:0]  awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;

    gb_frame_ctrl #(.IN_PIXELS(IN), .OUT_PIXELS(OUT), .TIMEOUT(8)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .busy(busy), .done(done),
        .timeout_err(timeout_err),
        .src_TDATA(src_TDATA), .src_TVALID(src_TVALID), .src_TREADY(src_TREADY),
        .arg_1_TDATA(arg_1_TDATA), .arg_1_TVALID(arg_1_TVALID), .arg_1_TREADY(arg_1_TREADY),
        .arg_1_TLAST(arg_1_TLAST),
        .arg_0_TVALID(arg_0_TVALID), .arg_0_TREADY(arg_0_TREADY), .interrupt(interrupt),
        .m_axi_config_AWVALID(awvalid), .m_axi_config_AWREADY(awready), .m_axi_config_AWADDR(awaddr),
        .m_axi_config_WVALID(wvalid), .m_axi_config_WREADY(wready), .m_axi_config_WDATA(wdata),
        .m_axi_config_WSTRB(wstrb), .m_axi_config_BVALID(bvalid), .m_axi_config_BREADY(bready),
        .m_axi_config_BRESP(bresp)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // environment state
    int          cyc = 0;
    logic [7:0]  src_q[$];
    logic [7:0]  exp_px[$];
    logic [7:0]  rx_data[$];
    logic        rx_last[$];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          tr_mode = 0, aw_lat = 0, w_lat = 0, a0_gap_max = 0, a0_gap = 0;
    int          out_left = 0, irq_delay = 0, irq_cnt = 0;
    int          aw_wait = 0, w_wait = 0, cur_addr = 0;
    logic [31:0] cur_data = 0;
    int          err_addr = 0, done_cnt = 0, hold_viol = 0, strb_bad = 0;
    int          b_cyc = 0, err_seen_cyc = -1;
    bit          src_en = 0, irq_arm = 0, irq_level = 0, err_en = 0;
    bit          aw_got = 0, w_got = 0, b_pend = 0, stalled_prev = 0;
    logic [1:0]  bresp_val = 2'b00;
    logic [7:0]  stalled_data = 8'h00;
    logic        stalled_last = 1'b0;
    logic        rdy, rdy_h0 = 1'b1, rdy_h1 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // drive at negedge, sample at negedge+1: the sampled values are what the next posedge sees
    initial begin
        src_TVALID = 0; src_TDATA = 0; arg_1_TREADY = 0; arg_0_TVALID = 0; interrupt = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(negedge ap_clk);
            cyc++;
            src_TVALID = src_en && (src_q.size() > 0);
            src_TDATA  = src_TVALID ? src_q[0] : 8'h00;
            case (tr_mode)
                0:       rdy = 1'b1;
                1:       rdy = !arg_1_TREADY;
                default: rdy = (!rdy_h0 && !rdy_h1) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            arg_1_TREADY = rdy;
            rdy_h1 = rdy_h0;
            rdy_h0 = rdy;
            arg_0_TVALID = (out_left > 0) && (a0_gap == 0);
            if (irq_arm && out_left == 0 && rx_data.size() == IN) begin
                if (irq_cnt >= irq_delay) begin
                    irq_level = 1;
                    irq_arm = 0;
                end else irq_cnt++;
            end
            interrupt = irq_level;
            awready = (awvalid === 1'b1) && !aw_got && (aw_wait >= aw_lat);
            wready  = (wvalid === 1'b1) && !w_got && (w_wait >= w_lat);
            bvalid  = b_pend;
            bresp   = b_pend ? bresp_val : 2'b00;
            #1;
            if (done === 1'b1) done_cnt++;
            if (src_TVALID && src_TREADY === 1'b1) void'(src_q.pop_front());
            if (arg_1_TVALID === 1'b1) begin
                if (stalled_prev && (arg_1_TDATA !== stalled_data || arg_1_TLAST !== stalled_last)) hold_viol++;
                if (arg_1_TREADY) begin
                    rx_data.push_back(arg_1_TDATA);
                    rx_last.push_back(arg_1_TLAST);
                    stalled_prev = 0;
                end else begin
                    stalled_prev = 1;
                    stalled_data = arg_1_TDATA;
                    stalled_last = arg_1_TLAST;
                end
            end else begin
                if (stalled_prev) hold_viol++;
                stalled_prev = 0;
            end
            if (arg_0_TVALID && arg_0_TREADY === 1'b1) begin
                out_left--;
                a0_gap = int'($urandom_range(0, a0_gap_max));
            end else if (a0_gap > 0) a0_gap--;
            if (awvalid === 1'b1 && awready) begin
                aw_got = 1; cur_addr = int'(awaddr); aw_wait = 0;
                if (awaddr == 5'h0C) irq_level = 0;
            end else if (awvalid === 1'b1 && !aw_got) aw_wait++;
            if (wvalid === 1'b1 && wready) begin
                w_got = 1; cur_data = wdata; w_wait = 0;
                if (wstrb !== 4'hF) strb_bad++;
            end else if (wvalid === 1'b1 && !w_got) w_wait++;
            if (bvalid && bready === 1'b1) begin
                b_pend = 0; aw_got = 0; w_got = 0; b_cyc = cyc;
            end else if (aw_got && w_got && !b_pend) begin
                b_pend = 1;
                wr_addr_q.push_back(cur_addr);
                wr_data_q.push_back(cur_data);
                bresp_val = (err_en && cur_addr == err_addr) ? 2'b10 : 2'b00;
            end
            if (timeout_err === 1'b1 && err_seen_cyc < 0) err_seen_cyc = cyc;
        end
    end

    task automatic prep(input int trm, input int awl, input int wl, input int gmax, input bit with_src, input int nout);
        logic [7:0] b;
        src_q.delete(); exp_px.delete(); rx_data.delete(); rx_last.delete();
        wr_addr_q.delete(); wr_data_q.delete();
        for (int i = 0; i < IN; i++) begin
            b = 8'($urandom);
            src_q.push_back(b);
            exp_px.push_back(b);
        end
        tr_mode = trm; aw_lat = awl; w_lat = wl; a0_gap_max = gmax; a0_gap = 0;
        src_en = with_src; out_left = nout;
        irq_arm = 1; irq_cnt = 0; irq_delay = int'($urandom_range(0, 3)); irq_level = 0;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_pend = 0; err_en = 0;
        done_cnt = 0; hold_viol = 0; stalled_prev = 0; strb_bad = 0; err_seen_cyc = -1;
    endtask

    task automatic start_pulse(input int n);
        @(negedge ap_clk);
        start = 1'b1;
        repeat (n) @(negedge ap_clk);
        start = 1'b0;
        #2;
    endtask

    task automatic wait_idle(input string t, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge ap_clk); #2;
            if (busy === 1'b0) break;
        end
        chk1({t, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_err(input string t, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge ap_clk); #2;
            if (timeout_err === 1'b1) break;
        end
        chk1({t, "_err"}, timeout_err, 1'b1);
    endtask

    task automatic wait_rx(input string t, input int cnt, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge ap_clk); #2;
            if (rx_data.size() >= cnt) break;
        end
        chk1({t, "_rx_reached"}, rx_data.size() >= cnt, 1'b1);
    endtask

    // reference: a good frame is GIE, IER, ap_start, ISR writes of 1, then every pixel in order, TLAST on the last
    task automatic check_frame(input string t);
        int exp_addr[4];
        exp_addr = '{4, 8, 0, 12};
        chk({t, "_nwr"}, wr_addr_q.size(), 4);
        if (wr_addr_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk({t, "_addr"}, wr_addr_q[i], exp_addr[i]);
                chk({t, "_wdata"}, wr_data_q[i], 32'd1);
            end
        end
        chk({t, "_nrx"}, rx_data.size(), IN);
        if (rx_data.size() == IN) begin
            for (int i = 0; i < IN; i++) begin
                chk({t, "_px"}, 32'(rx_data[i]), 32'(exp_px[i]));
                chk1({t, "_tlast"}, rx_last[i], i == IN - 1);
            end
        end
        chk({t, "_done_cnt"}, done_cnt, 1);
        chk({t, "_hold"}, hold_viol, 0);
        chk({t, "_strb"}, strb_bad, 0);
        chk({t, "_out_left"}, out_left, 0);
        chk1({t, "_terr"}, timeout_err, 1'b0);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_terr", timeout_err, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_a1_tvalid", arg_1_TVALID, 1'b0);
        chk1("rst_a1_tlast", arg_1_TLAST, 1'b0);
        chk1("rst_src_tready", src_TREADY, 1'b0);
        chk1("rst_a0_tready", arg_0_TREADY, 1'b0);
        chk("rst_awaddr", 32'(awaddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);

        // nominal frame, no stalls
        prep(0, 0, 0, 0, 1, OUT);
        start_pulse(1);
        chk1("nom_busy", busy, 1'b1);
        wait_idle("nom", 200);
        check_frame("nom");

        // arg_1 ready toggling, AWREADY 3 cycles after WREADY
        prep(1, 3, 0, 0, 1, OUT);
        start_pulse(1);
        wait_idle("tog", 200);
        check_frame("tog");

        // randomized stalls and latencies
        for (int r = 0; r < 3; r++) begin
            prep(2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1, OUT);
            start_pulse(1);
            wait_idle("rnd", 300);
            check_frame("rnd");
        end

        // error response on the IER write
        prep(0, 0, 0, 0, 1, OUT);
        err_en = 1; err_addr = 8;
        start_pulse(1);
        wait_err("berr", 100);
        repeat (5) @(negedge ap_clk);
        #2;
        chk1("berr_busy", busy, 1'b1);
        chk("berr_nwr", wr_addr_q.size(), 2);
        chk("berr_last_addr", wr_addr_q.size() > 1 ? wr_addr_q[1] : -1, 8);
        chk("berr_done_cnt", done_cnt, 0);
        chk1("berr_awvalid", awvalid, 1'b0);
        chk1("berr_bready", bready, 1'b0);
        chk1("berr_src_tready", src_TREADY, 1'b0);
        chk1("berr_a0_tready", arg_0_TREADY, 1'b0);

        // restart from ERR gives a clean frame
        prep(0, 0, 0, 0, 1, OUT);
        start_pulse(2);
        chk1("restart_terr_clr", timeout_err, 1'b0);
        wait_idle("restart", 200);
        check_frame("restart");

        // source stuck: watchdog after 8 idle cycles in RUN
        prep(0, 0, 0, 0, 0, 0);
        start_pulse(1);
        wait_err("to", 100);
        chk("to_idle_cycles", 32'(err_seen_cyc - b_cyc), 32'd9);
        chk("to_nwr", wr_addr_q.size(), 3);
        prep(0, 0, 0, 0, 1, OUT);
        start_pulse(2);
        wait_idle("to_restart", 200);
        check_frame("to_restart");

        // reset after two input beats
        prep(0, 0, 0, 0, 1, OUT);
        start_pulse(1);
        wait_rx("rstmid", 2, 100);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #2;
        chk1("rstmid_busy", busy, 1'b0);
        chk1("rstmid_a1_tvalid", arg_1_TVALID, 1'b0);
        chk1("rstmid_a0_tready", arg_0_TREADY, 1'b0);
        chk("rstmid_done_cnt", done_cnt, 0);
        prep(0, 0, 0, 0, 1, OUT);
        start_pulse(1);
        wait_idle("rstmid_new", 200);
        check_frame("rstmid_new");

        // start pulsed mid-frame is ignored
        prep(1, 0, 0, 0, 1, OUT);
        start_pulse(1);
        wait_rx("midstart", 1, 100);
        start_pulse(1);
        chk1("midstart_busy", busy, 1'b1);
        wait_idle("midstart", 200);
        repeat (6) @(negedge ap_clk);
        #2;
        chk1("midstart_stay_idle", busy, 1'b0);
        check_frame("midstart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
